tnoc_flit_receiver: RTL and testbench
=====================================

Name: tnoc_flit_receiver

Overview:
- Ingress-side packet parser of a tnoc network interface. Sits directly downstream of the router's local output port.
- Consumes the raw flit stream and validates each header flit against the shared packet-type, routing, burst and response-status encodings.
- Emits decoded header fields on one valid/ready channel and payload flits on a second valid/ready channel. Malformed packets are dropped and flagged.

Parameters:
- FLIT_WIDTH, 64, flit data width; must be >= 21.
- LEN_WIDTH, 8, width of the header burst-length field.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_flit_valid  input  1  flit valid
- o_flit_ready  output  1  flit ready
- i_flit_type  input  1  0 = header flit, 1 = payload flit
- i_flit_tail  input  1  last flit of the packet
- i_flit_data  input  FLIT_WIDTH  flit data
- o_header_valid  output  1  decoded header valid
- i_header_ready  input  1  header accepted
- o_packet_type  output  8  packet-type encoding
- o_routing_mode  output  1  0 = X-Y routing, 1 = Y-X routing
- o_burst_type  output  2  burst type
- o_response_status  output  2  response status; forced to 0 for non-response packet types
- o_burst_length  output  LEN_WIDTH  payload flit count minus 1
- o_payload_valid  output  1  payload valid
- i_payload_ready  input  1  payload accepted
- o_payload_data  output  FLIT_WIDTH  payload data
- o_payload_last  output  1  last payload flit of the packet
- o_invalid_packet  output  1  one-cycle pulse: illegal packet type
- o_protocol_error  output  1  one-cycle pulse: framing error

Behaviour:
- Header flit layout: data[7:0] type, [8] routing, [10:9] burst, [12:11] status, [20:13] length (for LEN_WIDTH=8).
- Legal packet types: 0x20 READ, 0x40 POSTED_WRITE, 0x60 NON_POSTED_WRITE, 0x80 RESPONSE, 0xC0 RESPONSE_WITH_DATA.
  - All other values, including 0x00, are invalid.
  - Type bit 6 = has payload. Type bit 7 = response.
- Flit handshake: a flit is taken in the cycle where i_flit_valid && o_flit_ready.
- Header channel: output register with 1-cycle latency. Fields hold stable while o_header_valid && !i_header_ready.
- Payload channel: same register rule, 1-cycle latency.
- State machine, states IDLE, PAYLOAD, DROP; reset state IDLE.
- o_flit_ready by state:
  - IDLE: !o_header_valid || i_header_ready
  - PAYLOAD: !o_payload_valid || i_payload_ready
  - DROP: 1
- IDLE, header flit taken, legal type, framing correct (tail == !has_payload):
  - Load header register.
  - If has payload: payload counter <= length+1, go to PAYLOAD. Otherwise stay in IDLE.
- IDLE, header flit taken, illegal type:
  - Pulse o_invalid_packet. No header is emitted.
  - Tail=1: stay in IDLE. Tail=0: go to DROP.
- IDLE, legal type but tail mismatched to has_payload:
  - Pulse o_protocol_error. No header is emitted.
  - Tail=1: stay in IDLE. Tail=0: go to DROP.
- IDLE, payload flit taken:
  - Pulse o_protocol_error and discard the flit.
  - Tail=1: stay in IDLE. Tail=0: go to DROP.
- PAYLOAD, payload flit taken: forward the data and decrement the counter. last = (counter==1) || tail.
  - counter==1 and tail=1: go to IDLE.
  - tail=1 and counter>1: early tail. Pulse o_protocol_error, set last, go to IDLE.
  - counter==1 and tail=0: overrun. Pulse o_protocol_error, set last, go to DROP.
- PAYLOAD, header flit taken: pulse o_protocol_error, discard the flit, state and counter unchanged.
- DROP: every flit is consumed and discarded. Leave to IDLE when a tail flit is taken.
- Counter width is LEN_WIDTH+1, so length 0xFF means 256 flits without wrap.
- Error pulses are registered and fire in the cycle after the offending flit. Both flags never fire for the same flit; invalid type has priority.
- Header and payload channels are independent. The payload may be presented before the header has been accepted.
- Reset, asynchronous, mid-packet: state returns to IDLE and the counter clears. All outputs go to 0: valid flags, data and fields, last, error pulses, and o_flit_ready. o_flit_ready takes its combinational IDLE value from the first cycle after reset release.

Test Plan:
- READ header (type 0x20, routing 1, tail 1) -> header_valid next cycle with type 0x20, routing_mode 1; no payload; no errors.
- POSTED_WRITE header (length 3) followed by 4 payload flits D0..D3, tail on D3 -> 4 payload beats; last only on D3; state back to IDLE.
- Header type 0x00, tail 0, then 2 payload flits, tail on the second -> one o_invalid_packet pulse; no header or payload emitted; all 3 flits consumed.
- RESPONSE_WITH_DATA header (length 3) with tail on the 2nd payload flit -> 2 payload beats, last on the 2nd, one o_protocol_error pulse.
- POSTED_WRITE header (length 0) followed by payload flits with tail=0 and then tail=1 -> 1 beat with last=1, protocol error, 2nd flit dropped.
- i_header_ready and i_payload_ready held low for 5 cycles during an NON_POSTED_WRITE packet -> output fields stable, o_flit_ready low, no flit lost.
- Assert i_rst mid-payload -> all outputs 0 immediately; next packet is parsed correctly from IDLE.

Source files
------------

// File: rtl/tnoc_flit_receiver.sv
// tnoc_flit_receiver: parses the router's local-port flit stream into a registered header channel
// and a registered payload channel, dropping malformed packets.
module tnoc_flit_receiver #(
    parameter int FLIT_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flit_valid,
    output logic                  o_flit_ready,
    input  logic                  i_flit_type,
    input  logic                  i_flit_tail,
    input  logic [FLIT_WIDTH-1:0] i_flit_data,
    output logic                  o_header_valid,
    input  logic                  i_header_ready,
    output logic [7:0]            o_packet_type,
    output logic                  o_routing_mode,
    output logic [1:0]            o_burst_type,
    output logic [1:0]            o_response_status,
    output logic [LEN_WIDTH-1:0]  o_burst_length,
    output logic                  o_payload_valid,
    input  logic                  i_payload_ready,
    output logic [FLIT_WIDTH-1:0] o_payload_data,
    output logic                  o_payload_last,
    output logic                  o_invalid_packet,
    output logic                  o_protocol_error
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
    localparam logic [LEN_WIDTH:0] ONE = (LEN_WIDTH+1)'(1);
    state_t state, state_next;
    logic [LEN_WIDTH:0] cnt, cnt_next;
    logic take, legal, has_payload, load_hdr, fwd, fwd_last, inv_next, perr_next;
    logic [7:0] ftype;
    logic [LEN_WIDTH-1:0] flen;
    assign ftype = i_flit_data[7:0];
    assign flen = i_flit_data[13 +: LEN_WIDTH];
    assign legal = ftype inside {8'h20, 8'h40, 8'h60, 8'h80, 8'hC0};
    assign has_payload = ftype[6];
    assign o_flit_ready = i_rst ? 1'b0 :
                          state == IDLE    ? (!o_header_valid || i_header_ready) :
                          state == PAYLOAD ? (!o_payload_valid || i_payload_ready) : 1'b1;
    assign take = i_flit_valid && o_flit_ready;
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        load_hdr = 1'b0;
        fwd = 1'b0;
        fwd_last = 1'b0;
        inv_next = 1'b0;
        perr_next = 1'b0;
        if (take) begin
            case (state)
                IDLE: begin
                    if (!i_flit_type && !legal) begin
                        inv_next = 1'b1;
                        state_next = i_flit_tail ? IDLE : DROP;
                    end else if (i_flit_type || i_flit_tail == has_payload) begin
                        perr_next = 1'b1;
                        state_next = i_flit_tail ? IDLE : DROP;
                    end else begin
                        load_hdr = 1'b1;
                        if (has_payload) begin
                            cnt_next = {1'b0, flen} + ONE;
                            state_next = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // Header flits inside a packet are discarded without disturbing the burst.
                    if (i_flit_type) begin
                        fwd = 1'b1;
                        cnt_next = cnt - ONE;
                        fwd_last = (cnt == ONE) || i_flit_tail;
                        if (i_flit_tail) begin
                            perr_next = cnt != ONE;
                            state_next = IDLE;
                        end else if (cnt == ONE) begin
                            perr_next = 1'b1;
                            state_next = DROP;
                        end
                    end else begin
                        perr_next = 1'b1;
                    end
                end
                default: state_next = i_flit_tail ? IDLE : DROP;
            endcase
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt <= '0;
            o_header_valid <= 1'b0;
            o_packet_type <= '0;
            o_routing_mode <= 1'b0;
            o_burst_type <= '0;
            o_response_status <= '0;
            o_burst_length <= '0;
            o_payload_valid <= 1'b0;
            o_payload_data <= '0;
            o_payload_last <= 1'b0;
            o_invalid_packet <= 1'b0;
            o_protocol_error <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            o_invalid_packet <= inv_next;
            o_protocol_error <= perr_next;
            if (!o_header_valid || i_header_ready) o_header_valid <= load_hdr;
            if (load_hdr) begin
                o_packet_type <= ftype;
                o_routing_mode <= i_flit_data[8];
                o_burst_type <= i_flit_data[10:9];
                o_response_status <= ftype[7] ? i_flit_data[12:11] : 2'b00;
                o_burst_length <= flen;
            end
            if (!o_payload_valid || i_payload_ready) o_payload_valid <= fwd;
            if (fwd) begin
                o_payload_data <= i_flit_data;
                o_payload_last <= fwd_last;
            end
        end
    end
endmodule

// File: tb/tb_tnoc_flit_receiver.sv
// tb_tnoc_flit_receiver: directed scenarios for the flit receiver with negedge output monitors.
module tb_tnoc_flit_receiver;
    localparam int FW = 64;
    localparam int LW = 8;
    logic clk = 1'b0;
    logic rst;
    logic i_flit_valid, o_flit_ready, i_flit_type, i_flit_tail;
    logic [FW-1:0] i_flit_data;
    logic o_header_valid, i_header_ready;
    logic [7:0] o_packet_type;
    logic o_routing_mode;
    logic [1:0] o_burst_type, o_response_status;
    logic [LW-1:0] o_burst_length;
    logic o_payload_valid, i_payload_ready;
    logic [FW-1:0] o_payload_data;
    logic o_payload_last, o_invalid_packet, o_protocol_error;
    int n_checks = 0;
    int n_fail = 0;
    int inv_cnt = 0;
    int perr_cnt = 0;
    logic [20:0] hq[$];
    logic [FW:0] pq[$];

    always #5 clk = ~clk;

    tnoc_flit_receiver #(.FLIT_WIDTH(FW), .LEN_WIDTH(LW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_flit_valid(i_flit_valid), .o_flit_ready(o_flit_ready),
        .i_flit_type(i_flit_type), .i_flit_tail(i_flit_tail), .i_flit_data(i_flit_data),
        .o_header_valid(o_header_valid), .i_header_ready(i_header_ready),
        .o_packet_type(o_packet_type), .o_routing_mode(o_routing_mode),
        .o_burst_type(o_burst_type), .o_response_status(o_response_status),
        .o_burst_length(o_burst_length),
        .o_payload_valid(o_payload_valid), .i_payload_ready(i_payload_ready),
        .o_payload_data(o_payload_data), .o_payload_last(o_payload_last),
        .o_invalid_packet(o_invalid_packet), .o_protocol_error(o_protocol_error)
    );

    // Accepted transfers are logged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (o_header_valid && i_header_ready)
            hq.push_back({o_burst_length, o_response_status, o_burst_type, o_routing_mode, o_packet_type});
        if (o_payload_valid && i_payload_ready) pq.push_back({o_payload_last, o_payload_data});
        if (o_invalid_packet) inv_cnt++;
        if (o_protocol_error) perr_cnt++;
    end

    function automatic logic [FW-1:0] hdr(input logic [7:0] t, input logic r, input logic [1:0] b,
                                          input logic [1:0] s, input logic [7:0] l);
        hdr = '0;
        hdr[20:0] = {l, s, b, r, t};
    endfunction

    task automatic push(input logic t, input logic tl, input logic [FW-1:0] d);
        int n = 0;
        @(negedge clk);
        i_flit_valid = 1'b1;
        i_flit_type = t;
        i_flit_tail = tl;
        i_flit_data = d;
        while (!o_flit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_flit_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: flit %h never accepted (ready=%b, required 1)", d, o_flit_ready);
        end else begin
            @(posedge clk);
        end
        #1 i_flit_valid = 1'b0;
    endtask

    task automatic clear();
        @(posedge clk);
        #1;
        hq.delete();
        pq.delete();
        inv_cnt = 0;
        perr_cnt = 0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({o_flit_ready, o_header_valid, o_payload_valid, o_invalid_packet, o_protocol_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {o_flit_ready, o_header_valid, o_payload_valid, o_invalid_packet, o_protocol_error});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (o_flit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", o_flit_ready);
        end
    endtask

    task automatic test_read();
        clear();
        push(1'b0, 1'b1, hdr(8'h20, 1'b1, 2'd0, 2'd2, 8'd5));
        n_checks++;
        if ({o_header_valid, o_packet_type} !== {1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL read_latency: got valid/type %b/%h required 1/20", o_header_valid, o_packet_type);
        end
        settle();
        n_checks++;
        if (hq.size() !== 1 || hq[0] !== {8'd5, 2'd0, 2'd0, 1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL read_header: got n=%0d %h required n=1 %h", hq.size(), hq.size() ? hq[0] : 21'h0,
                     {8'd5, 2'd0, 2'd0, 1'b1, 8'h20});
        end
        n_checks++;
        if ({pq.size(), inv_cnt, perr_cnt} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL read_side_effects: got payloads=%0d inv=%0d perr=%0d required 0/0/0",
                     pq.size(), inv_cnt, perr_cnt);
        end
    endtask

    task automatic test_posted_write();
        clear();
        push(1'b0, 1'b0, hdr(8'h40, 1'b0, 2'd1, 2'd2, 8'd3));
        for (int i = 0; i < 4; i++) push(1'b1, i == 3, FW'(64'hA0 + i));
        settle();
        n_checks++;
        if (hq.size() !== 1 || hq[0] !== {8'd3, 2'd0, 2'd1, 1'b0, 8'h40}) begin
            n_fail++;
            $display("FAIL pw_header: got n=%0d %h required n=1 %h", hq.size(), hq.size() ? hq[0] : 21'h0,
                     {8'd3, 2'd0, 2'd1, 1'b0, 8'h40});
        end
        n_checks++;
        if (pq.size() !== 4) begin
            n_fail++;
            $display("FAIL pw_beats: got %0d required 4", pq.size());
        end
        for (int i = 0; i < 4 && i < pq.size(); i++) begin
            n_checks++;
            if (pq[i] !== {i == 3, FW'(64'hA0 + i)}) begin
                n_fail++;
                $display("FAIL pw_beat%0d: got %h required %h", i, pq[i], {i == 3, FW'(64'hA0 + i)});
            end
        end
        n_checks++;
        if (inv_cnt + perr_cnt !== 0) begin
            n_fail++;
            $display("FAIL pw_errors: got %0d required 0", inv_cnt + perr_cnt);
        end
    endtask

    task automatic test_invalid_type();
        clear();
        push(1'b0, 1'b0, hdr(8'h00, 1'b0, 2'd0, 2'd0, 8'd1));
        push(1'b1, 1'b0, FW'(64'hB0));
        push(1'b1, 1'b1, FW'(64'hB1));
        settle();
        n_checks++;
        if ({inv_cnt, perr_cnt} !== {32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL inv_flags: got inv=%0d perr=%0d required 1/0", inv_cnt, perr_cnt);
        end
        n_checks++;
        if ({hq.size(), pq.size()} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL inv_emitted: got hdr=%0d pay=%0d required 0/0", hq.size(), pq.size());
        end
    endtask

    task automatic test_early_tail();
        clear();
        push(1'b0, 1'b0, hdr(8'hC0, 1'b0, 2'd0, 2'd3, 8'd3));
        push(1'b1, 1'b0, FW'(64'hC0DE0));
        push(1'b1, 1'b1, FW'(64'hC0DE1));
        settle();
        n_checks++;
        if (hq.size() !== 1 || hq[0] !== {8'd3, 2'd3, 2'd0, 1'b0, 8'hC0}) begin
            n_fail++;
            $display("FAIL early_header: got n=%0d %h required n=1 %h", hq.size(), hq.size() ? hq[0] : 21'h0,
                     {8'd3, 2'd3, 2'd0, 1'b0, 8'hC0});
        end
        n_checks++;
        if (pq.size() !== 2 || pq[0] !== {1'b0, FW'(64'hC0DE0)} || pq[1] !== {1'b1, FW'(64'hC0DE1)}) begin
            n_fail++;
            $display("FAIL early_beats: got n=%0d required 2 beats C0DE0, C0DE1+last", pq.size());
        end
        n_checks++;
        if ({inv_cnt, perr_cnt} !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL early_flags: got inv=%0d perr=%0d required 0/1", inv_cnt, perr_cnt);
        end
    endtask

    task automatic test_overrun();
        clear();
        push(1'b0, 1'b0, hdr(8'h40, 1'b0, 2'd0, 2'd0, 8'd0));
        push(1'b1, 1'b0, FW'(64'hE0));
        push(1'b1, 1'b1, FW'(64'hE1));
        settle();
        n_checks++;
        if (pq.size() !== 1 || pq[0] !== {1'b1, FW'(64'hE0)}) begin
            n_fail++;
            $display("FAIL overrun_beats: got n=%0d first=%h required n=1 %h", pq.size(),
                     pq.size() ? pq[0] : 65'h0, {1'b1, FW'(64'hE0)});
        end
        n_checks++;
        if ({inv_cnt, perr_cnt} !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL overrun_flags: got inv=%0d perr=%0d required 0/1", inv_cnt, perr_cnt);
        end
    endtask

    task automatic test_back_pressure();
        clear();
        i_header_ready = 1'b0;
        i_payload_ready = 1'b0;
        push(1'b0, 1'b0, hdr(8'h60, 1'b1, 2'd2, 2'd1, 8'd1));
        push(1'b1, 1'b0, FW'(64'hD0));
        fork
            push(1'b1, 1'b1, FW'(64'hD1));
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({o_flit_ready, o_header_valid, o_packet_type, o_burst_length, o_payload_valid, o_payload_data}
                        !== {1'b0, 1'b1, 8'h60, 8'd1, 1'b1, FW'(64'hD0)}) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got rdy=%b hv=%b type=%h len=%h pv=%b data=%h required 0/1/60/01/1/d0",
                                 i, o_flit_ready, o_header_valid, o_packet_type, o_burst_length,
                                 o_payload_valid, o_payload_data);
                    end
                end
                @(posedge clk);
                #1;
                i_header_ready = 1'b1;
                i_payload_ready = 1'b1;
            end
        join
        settle();
        n_checks++;
        if (hq.size() !== 1 || hq[0] !== {8'd1, 2'd0, 2'd2, 1'b1, 8'h60}) begin
            n_fail++;
            $display("FAIL stall_header: got n=%0d %h required n=1 %h", hq.size(), hq.size() ? hq[0] : 21'h0,
                     {8'd1, 2'd0, 2'd2, 1'b1, 8'h60});
        end
        n_checks++;
        if (pq.size() !== 2 || pq[0] !== {1'b0, FW'(64'hD0)} || pq[1] !== {1'b1, FW'(64'hD1)}) begin
            n_fail++;
            $display("FAIL stall_beats: got n=%0d required 2 beats d0, d1+last", pq.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        clear();
        push(1'b0, 1'b0, hdr(8'h40, 1'b0, 2'd0, 2'd0, 8'd3));
        push(1'b1, 1'b0, FW'(64'hF0));
        push(1'b1, 1'b0, FW'(64'hF1));
        n_checks++;
        if ({o_payload_valid, o_payload_data} !== {1'b1, FW'(64'hF1)}) begin
            n_fail++;
            $display("FAIL midrst_before: got pv=%b data=%h required 1/f1", o_payload_valid, o_payload_data);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_flit_ready, o_header_valid, o_payload_valid, o_payload_last, o_payload_data, o_packet_type} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy=%b hv=%b pv=%b last=%b data=%h type=%h required all 0",
                     o_flit_ready, o_header_valid, o_payload_valid, o_payload_last, o_payload_data, o_packet_type);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear();
        push(1'b0, 1'b1, hdr(8'h80, 1'b1, 2'd3, 2'd1, 8'd0));
        settle();
        n_checks++;
        if (hq.size() !== 1 || hq[0] !== {8'd0, 2'd1, 2'd3, 1'b1, 8'h80} || perr_cnt !== 0) begin
            n_fail++;
            $display("FAIL midrst_next: got n=%0d %h perr=%0d required n=1 %h perr=0", hq.size(),
                     hq.size() ? hq[0] : 21'h0, perr_cnt, {8'd0, 2'd1, 2'd3, 1'b1, 8'h80});
        end
    endtask

    initial begin
        i_flit_valid = 1'b0;
        i_flit_type = 1'b0;
        i_flit_tail = 1'b0;
        i_flit_data = '0;
        i_header_ready = 1'b1;
        i_payload_ready = 1'b1;
        test_reset();
        test_read();
        test_posted_write();
        test_invalid_type();
        test_early_tail();
        test_overrun();
        test_back_pressure();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
